// File: rtl/lego_multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the LEGv8 subset datapath.
// Optional feature macro: CTRL_CBNZ_EN (decode 10110101 as CBNZ instead of illegal).
module lego_multicycle_ctrl (
   input  logic        CLK,
   input  logic        resetl,
   input  logic [31:0] Instr,
   input  logic        Zero,
   input  logic        mem_ready,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic [1:0]  PCSrc,
   output logic        IMemRead,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        RegWrite,
   output logic        MemToReg,
   output logic        ALUSrc,
   output logic        Reg2Loc,
   output logic [1:0]  SignOp,
   output logic        ImmUnsigned,
   output logic [3:0]  ALUOp,
   output logic        illegal,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_e;

   typedef enum logic [2:0] {
      C_NONE = 3'd0,
      C_R    = 3'd1,
      C_I    = 3'd2,
      C_D    = 3'd3,
      C_B    = 3'd4,
      C_CB   = 3'd5
   } cls_e;

   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_ORR  = 4'b0001;
   localparam logic [3:0] ALU_PASS = 4'b0111;

   state_e     state_q, state_d;
   cls_e       cls_s;
   logic [3:0] alu_op_s;
   logic       is_load_s;
   logic       is_cbnz_s;
   logic [1:0] sign_op_s;
   logic       imm_uns_s;
   logic       alu_src_s;
   logic       reg2loc_s;
   logic       unused_s;

   assign unused_s = ^Instr[20:0];

   // Opcode classification as a priority match; also yields per-class datapath selects.
   always_comb begin
      cls_s     = C_NONE;
      alu_op_s  = 4'b0000;
      is_load_s = 1'b0;
      is_cbnz_s = 1'b0;
      reg2loc_s = 1'b0;
      if (Instr[31:21] == 11'b10001011000) begin
         cls_s = C_R; alu_op_s = ALU_ADD;
      end else if (Instr[31:21] == 11'b11001011000) begin
         cls_s = C_R; alu_op_s = ALU_SUB;
      end else if (Instr[31:21] == 11'b10001010000) begin
         cls_s = C_R; alu_op_s = ALU_AND;
      end else if (Instr[31:21] == 11'b10101010000) begin
         cls_s = C_R; alu_op_s = ALU_ORR;
      end else if (Instr[31:22] == 10'b1001000100) begin
         cls_s = C_I; alu_op_s = ALU_ADD;
      end else if (Instr[31:22] == 10'b1101000100) begin
         cls_s = C_I; alu_op_s = ALU_SUB;
      end else if (Instr[31:21] == 11'b11111000010) begin
         cls_s = C_D; alu_op_s = ALU_ADD; is_load_s = 1'b1;
      end else if (Instr[31:21] == 11'b11111000000) begin
         cls_s = C_D; alu_op_s = ALU_ADD; reg2loc_s = 1'b1;
      end else if (Instr[31:26] == 6'b000101) begin
         cls_s = C_B;
      end else if (Instr[31:24] == 8'b10110100) begin
         cls_s = C_CB; alu_op_s = ALU_PASS; reg2loc_s = 1'b1;
`ifdef CTRL_CBNZ_EN
      end else if (Instr[31:24] == 8'b10110101) begin
         cls_s = C_CB; alu_op_s = ALU_PASS; reg2loc_s = 1'b1; is_cbnz_s = 1'b1;
`endif
      end else begin
         cls_s = C_NONE;
      end

      sign_op_s = 2'b00;
      imm_uns_s = 1'b0;
      alu_src_s = 1'b0;
      case (cls_s)
         C_I:     begin sign_op_s = 2'b00; imm_uns_s = 1'b1; alu_src_s = 1'b1; end
         C_D:     begin sign_op_s = 2'b01; alu_src_s = 1'b1; end
         C_B:     sign_op_s = 2'b10;
         C_CB:    sign_op_s = 2'b11;
         default: sign_op_s = 2'b00;
      endcase
   end

   // Next-state and output decode; reset forces every output low without waiting for a clock.
   always_comb begin
      state_d     = state_q;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCSrc       = 2'b00;
      IMemRead    = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      RegWrite    = 1'b0;
      MemToReg    = 1'b0;
      ALUSrc      = 1'b0;
      Reg2Loc     = 1'b0;
      SignOp      = 2'b00;
      ImmUnsigned = 1'b0;
      ALUOp       = 4'b0000;
      illegal     = 1'b0;
      if (!resetl) begin
         state_d = S_FETCH;
      end else begin
         if (state_q != S_FETCH) begin
            SignOp      = sign_op_s;
            ImmUnsigned = imm_uns_s;
            ALUSrc      = alu_src_s;
            Reg2Loc     = reg2loc_s;
            ALUOp       = alu_op_s;
         end else begin
            SignOp = 2'b00;
         end
         case (state_q)
            S_FETCH: begin
               IMemRead = 1'b1;
               if (mem_ready) begin
                  IRWrite = 1'b1;
                  PCWrite = 1'b1;
                  state_d = S_DECODE;
               end else begin
                  state_d = S_FETCH;
               end
            end
            S_DECODE: begin
               if (cls_s == C_NONE) begin
                  illegal = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_EXEC;
               end
            end
            S_EXEC: begin
               case (cls_s)
                  C_R, C_I: state_d = S_WB;
                  C_D:      state_d = S_MEM;
                  C_B: begin
                     PCWrite = 1'b1;
                     PCSrc   = 2'b01;
                     state_d = S_FETCH;
                  end
                  C_CB: begin
                     // CBZ takes the branch on Zero, CBNZ on its complement
                     if (Zero ^ is_cbnz_s) begin
                        PCWrite = 1'b1;
                        PCSrc   = 2'b10;
                     end else begin
                        PCWrite = 1'b0;
                     end
                     state_d = S_FETCH;
                  end
                  default: state_d = S_FETCH;
               endcase
            end
            S_MEM: begin
               MemRead  = is_load_s;
               MemWrite = ~is_load_s;
               if (mem_ready) begin
                  state_d = is_load_s ? S_WB : S_FETCH;
               end else begin
                  state_d = S_MEM;
               end
            end
            S_WB: begin
               RegWrite = 1'b1;
               MemToReg = is_load_s;
               state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
         endcase
      end
   end

   // State register.
   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_lego_multicycle_ctrl.sv
// Directed self-checking bench for lego_multicycle_ctrl; CBNZ expectations follow CTRL_CBNZ_EN.
module tb_lego_multicycle_ctrl;

   logic        CLK = 1'b0;
   logic        resetl;
   logic [31:0] Instr;
   logic        Zero;
   logic        mem_ready;
   logic        IRWrite, PCWrite, IMemRead, MemRead, MemWrite, RegWrite, MemToReg;
   logic        ALUSrc, Reg2Loc, ImmUnsigned, illegal;
   logic [1:0]  PCSrc, SignOp;
   logic [3:0]  ALUOp;
   logic [2:0]  state;

   int tests  = 0;
   int errors = 0;

   lego_multicycle_ctrl dut (
      .CLK(CLK), .resetl(resetl), .Instr(Instr), .Zero(Zero), .mem_ready(mem_ready),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .IMemRead(IMemRead),
      .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .MemToReg(MemToReg),
      .ALUSrc(ALUSrc), .Reg2Loc(Reg2Loc), .SignOp(SignOp), .ImmUnsigned(ImmUnsigned),
      .ALUOp(ALUOp), .illegal(illegal), .state(state)
   );

   always #5 CLK = ~CLK;

   // Drive one cycle's inputs in the low phase and let the combinational outputs settle.
   task automatic step(input logic [31:0] ins, input logic rdy, input logic z);
      @(negedge CLK);
      Instr = ins; mem_ready = rdy; Zero = z;
      #1;
   endtask

   task automatic test_reset;
      resetl = 1'b0; Instr = 32'h0; mem_ready = 1'b1; Zero = 1'b0;
      #12;
      tests++;
      if ({IRWrite, PCWrite, IMemRead, MemRead, MemWrite, RegWrite, illegal} !== 7'b0) begin
         errors++; $display("FAIL reset_enables got %b want 0000000",
            {IRWrite, PCWrite, IMemRead, MemRead, MemWrite, RegWrite, illegal});
      end
      tests++;
      if ({state, PCSrc, SignOp, ALUOp, ALUSrc, Reg2Loc, ImmUnsigned, MemToReg} !== 15'b0) begin
         errors++; $display("FAIL reset_selects got %b want all zero",
            {state, PCSrc, SignOp, ALUOp, ALUSrc, Reg2Loc, ImmUnsigned, MemToReg});
      end
      @(negedge CLK);
      resetl = 1'b1; mem_ready = 1'b0;
      #1;
      tests++;
      if (IMemRead !== 1'b1 || state !== 3'd0) begin
         errors++; $display("FAIL reset_release IMemRead=%b state=%0d want 1/0", IMemRead, state);
      end
      step(32'h0, 1'b0, 1'b0);
      tests++;
      if (state !== 3'd0 || IMemRead !== 1'b1 || IRWrite !== 1'b0 || PCWrite !== 1'b0) begin
         errors++; $display("FAIL fetch_stall state=%0d IMemRead=%b IRWrite=%b PCWrite=%b want 0/1/0/0",
            state, IMemRead, IRWrite, PCWrite);
      end
   endtask

   task automatic test_add;
      int exp_st [5] = '{0, 1, 2, 4, 0};
      for (int i = 0; i < 5; i++) begin
         step(32'h8B020020, (i == 4) ? 1'b0 : 1'b1, 1'b0);
         tests++;
         if (state !== 3'(exp_st[i])) begin
            errors++; $display("FAIL add_state[%0d] got %0d want %0d", i, state, exp_st[i]);
         end
         tests++;
         if (RegWrite !== (i == 3)) begin
            errors++; $display("FAIL add_regwrite[%0d] got %b want %b", i, RegWrite, (i == 3));
         end
         if (i == 0) begin
            tests++;
            if (IRWrite !== 1'b1 || PCWrite !== 1'b1 || PCSrc !== 2'b00) begin
               errors++; $display("FAIL add_fetch IRWrite=%b PCWrite=%b PCSrc=%b want 1/1/00",
                  IRWrite, PCWrite, PCSrc);
            end
         end
         if (i >= 1 && i <= 3) begin
            tests++;
            if (ALUSrc !== 1'b0 || MemToReg !== 1'b0 || ALUOp !== 4'b0010) begin
               errors++; $display("FAIL add_sel[%0d] ALUSrc=%b MemToReg=%b ALUOp=%b want 0/0/0010",
                  i, ALUSrc, MemToReg, ALUOp);
            end
         end
      end
   endtask

   task automatic test_addi;
      step(32'h91002020, 1'b1, 1'b0);
      step(32'h91002020, 1'b1, 1'b0);
      step(32'h91002020, 1'b1, 1'b0);
      tests++;
      if (state !== 3'd2 || ALUSrc !== 1'b1 || SignOp !== 2'b00 || ImmUnsigned !== 1'b1) begin
         errors++; $display("FAIL addi_exec state=%0d ALUSrc=%b SignOp=%b ImmUnsigned=%b want 2/1/00/1",
            state, ALUSrc, SignOp, ImmUnsigned);
      end
      step(32'h91002020, 1'b1, 1'b0);
      tests++;
      if (state !== 3'd4 || RegWrite !== 1'b1) begin
         errors++; $display("FAIL addi_wb state=%0d RegWrite=%b want 4/1", state, RegWrite);
      end
      step(32'h91002020, 1'b0, 1'b0);
   endtask

   task automatic test_ldur;
      int exp_st [8] = '{0, 1, 2, 3, 3, 3, 4, 0};
      int rdy    [8] = '{1, 1, 1, 0, 0, 1, 1, 0};
      int reads = 0;
      for (int i = 0; i < 8; i++) begin
         step(32'hF8408083, rdy[i][0], 1'b0);
         if (MemRead === 1'b1) reads++;
         tests++;
         if (state !== 3'(exp_st[i])) begin
            errors++; $display("FAIL ldur_state[%0d] got %0d want %0d", i, state, exp_st[i]);
         end
         if (i == 1) begin
            tests++;
            if (SignOp !== 2'b01) begin
               errors++; $display("FAIL ldur_signop got %b want 01", SignOp);
            end
         end
         if (i == 6) begin
            tests++;
            if (RegWrite !== 1'b1 || MemToReg !== 1'b1) begin
               errors++; $display("FAIL ldur_wb RegWrite=%b MemToReg=%b want 1/1", RegWrite, MemToReg);
            end
         end
      end
      tests++;
      if (reads != 3) begin
         errors++; $display("FAIL ldur_memread_cycles got %0d want 3", reads);
      end
   endtask

   task automatic test_stur;
      int exp_st [5] = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 5; i++) begin
         step(32'hF8008083, (i == 4) ? 1'b0 : 1'b1, 1'b0);
         tests++;
         if (state !== 3'(exp_st[i])) begin
            errors++; $display("FAIL stur_state[%0d] got %0d want %0d", i, state, exp_st[i]);
         end
         if (i == 3) begin
            tests++;
            if (MemWrite !== 1'b1 || MemRead !== 1'b0 || Reg2Loc !== 1'b1) begin
               errors++; $display("FAIL stur_mem MemWrite=%b MemRead=%b Reg2Loc=%b want 1/0/1",
                  MemWrite, MemRead, Reg2Loc);
            end
         end
      end
   endtask

   task automatic test_reset_mid_mem;
      step(32'hF8008083, 1'b1, 1'b0);
      step(32'hF8008083, 1'b1, 1'b0);
      step(32'hF8008083, 1'b1, 1'b0);
      step(32'hF8008083, 1'b0, 1'b0);
      tests++;
      if (state !== 3'd3 || MemWrite !== 1'b1) begin
         errors++; $display("FAIL midmem_pre state=%0d MemWrite=%b want 3/1", state, MemWrite);
      end
      #2;
      resetl = 1'b0;
      #1;
      tests++;
      if (MemWrite !== 1'b0 || state !== 3'd0 || IMemRead !== 1'b0) begin
         errors++; $display("FAIL midmem_reset MemWrite=%b state=%0d IMemRead=%b want 0/0/0",
            MemWrite, state, IMemRead);
      end
      @(negedge CLK);
      resetl = 1'b1;
      #1;
      tests++;
      if (IMemRead !== 1'b1 || state !== 3'd0 || MemWrite !== 1'b0) begin
         errors++; $display("FAIL midmem_release IMemRead=%b state=%0d MemWrite=%b want 1/0/0",
            IMemRead, state, MemWrite);
      end
   endtask

   task automatic test_cbz(input logic z);
      step(32'hB4000065, 1'b1, z);
      step(32'hB4000065, 1'b1, z);
      step(32'hB4000065, 1'b1, z);
      tests++;
      if (state !== 3'd2 || SignOp !== 2'b11 || Reg2Loc !== 1'b1 || ALUOp !== 4'b0111) begin
         errors++; $display("FAIL cbz_exec_sel state=%0d SignOp=%b Reg2Loc=%b ALUOp=%b want 2/11/1/0111",
            state, SignOp, Reg2Loc, ALUOp);
      end
      tests++;
      if (PCWrite !== z || (z && PCSrc !== 2'b10)) begin
         errors++; $display("FAIL cbz_branch zero=%b PCWrite=%b PCSrc=%b want %b/10", z, PCWrite, PCSrc, z);
      end
      step(32'hB4000065, 1'b0, z);
      tests++;
      if (state !== 3'd0) begin
         errors++; $display("FAIL cbz_done state=%0d want 0", state);
      end
   endtask

   task automatic test_b;
      int exp_st [4] = '{0, 1, 2, 0};
      int wrote = 0;
      for (int i = 0; i < 4; i++) begin
         step(32'h14000004, (i == 3) ? 1'b0 : 1'b1, 1'b0);
         if (RegWrite === 1'b1) wrote++;
         tests++;
         if (state !== 3'(exp_st[i])) begin
            errors++; $display("FAIL b_state[%0d] got %0d want %0d", i, state, exp_st[i]);
         end
         if (i == 2) begin
            tests++;
            if (PCWrite !== 1'b1 || PCSrc !== 2'b01 || SignOp !== 2'b10) begin
               errors++; $display("FAIL b_exec PCWrite=%b PCSrc=%b SignOp=%b want 1/01/10",
                  PCWrite, PCSrc, SignOp);
            end
         end
      end
      tests++;
      if (wrote != 0) begin
         errors++; $display("FAIL b_regwrite cycles=%0d want 0", wrote);
      end
   endtask

   task automatic test_illegal(input logic [31:0] ins, input string name);
      int exp_st [3] = '{0, 1, 0};
      int pulses = 0;
      for (int i = 0; i < 3; i++) begin
         step(ins, (i == 2) ? 1'b0 : 1'b1, 1'b0);
         if (illegal === 1'b1) pulses++;
         tests++;
         if (state !== 3'(exp_st[i])) begin
            errors++; $display("FAIL %s_state[%0d] got %0d want %0d", name, i, state, exp_st[i]);
         end
         if (i == 1) begin
            tests++;
            if (illegal !== 1'b1) begin
               errors++; $display("FAIL %s_pulse got %b want 1", name, illegal);
            end
         end
      end
      tests++;
      if (pulses != 1) begin
         errors++; $display("FAIL %s_pulse_cycles got %0d want 1", name, pulses);
      end
   endtask

   task automatic test_cbnz;
`ifdef CTRL_CBNZ_EN
      step(32'hB5000065, 1'b1, 1'b0);
      step(32'hB5000065, 1'b1, 1'b0);
      tests++;
      if (illegal !== 1'b0) begin
         errors++; $display("FAIL cbnz_decode illegal=%b want 0", illegal);
      end
      step(32'hB5000065, 1'b1, 1'b0);
      tests++;
      if (state !== 3'd2 || PCWrite !== 1'b1 || PCSrc !== 2'b10) begin
         errors++; $display("FAIL cbnz_exec state=%0d PCWrite=%b PCSrc=%b want 2/1/10", state, PCWrite, PCSrc);
      end
      step(32'hB5000065, 1'b0, 1'b0);
`else
      test_illegal(32'hB5000065, "cbnz");
`endif
   endtask

   initial begin
      test_reset();
      test_add();
      test_addi();
      test_ldur();
      test_stur();
      test_reset_mid_mem();
      test_cbz(1'b1);
      test_cbz(1'b0);
      test_b();
      test_illegal(32'h00000000, "illegal");
      test_cbnz();
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
